ps2_rx_controller: RTL and testbench

Receive-only PS/2 host interface: the keyboard/mouse device drives both lines. The block synchronizes ps2_clk and ps2_data into the system clock domain and deserializes 11-bit device-to-host frames (start, 8 data LSB-first, odd parity, stop). It presents each received byte with a one-cycle valid strobe and an error flag. It sits between the PS/2 pins and a keyboard scan-code consumer or peripheral register block.

---
 rtl/ps2_rx_controller.sv | 145 ++++++++++++++
 tb/tb_ps2_rx_controller.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_controller.sv
// PS/2 device-to-host receiver: synchronizes the pins, detects ps2_clk falls,
// and deserializes 11-bit frames (start, 8 data LSB-first, odd parity, stop).
module ps2_rx_controller #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s, data_s, fall;

  state_e            state_q, state_d;
  logic [2:0]        count_q, count_d;
  logic [7:0]        shift_q, shift_d;
  logic              parity_chk_q, parity_chk_d;
  logic              parity_bit_q, parity_bit_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              tmo_hit;
  logic [7:0]        data_q, data_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic              parity_chk;

  assign clk_s      = clk_sync_q[SYNC_STAGES-1];
  assign data_s     = data_sync_q[SYNC_STAGES-1];
  assign fall       = clk_prev_q & ~clk_s;
  assign parity_chk = parity_chk_q;
  assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (tmo_q == TW'(TIMEOUT_CYCLES));

  // Pin synchronizers, preset to the idle-high level so reset never looks like a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_s;
    end
  end

  // Frame state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      count_q      <= '0;
      shift_q      <= '0;
      parity_chk_q <= 1'b0;
      parity_bit_q <= 1'b0;
      tmo_q        <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      shift_q      <= shift_d;
      parity_chk_q <= parity_chk_d;
      parity_bit_q <= parity_bit_d;
      tmo_q        <= tmo_d;
      data_q       <= data_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
    end
  end

  // Next-state: advance one frame bit per detected fall; abort a stalled frame.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    shift_d      = shift_q;
    parity_chk_d = parity_chk_q;
    parity_bit_d = parity_bit_q;
    data_d       = data_q;
    err_d        = err_q;
    valid_d      = 1'b0;

    if (state_q == StIdle || fall) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    case (state_q)
      StIdle: begin
        if (fall && !data_s) begin
          state_d      = StData;
          count_d      = '0;
          shift_d      = '0;
          parity_chk_d = 1'b0;
        end
      end
      StData: begin
        if (fall) begin
          shift_d[count_q] = data_s;
          parity_chk_d     = parity_chk_q ^ data_s;
          if (count_q == 3'd7) begin
            state_d = StParity;
          end else begin
            count_d = count_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (fall) begin
          parity_bit_d = data_s;
          state_d      = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          state_d = StIdle;
          valid_d = 1'b1;
          data_d  = shift_q;
          // Odd parity fails when the parity bit equals the data XOR.
          err_d   = (parity_bit_q == parity_chk_q) | ~data_s;
        end
      end
      default: state_d = StIdle;
    endcase

    // Silent abort: no strobe, held outputs untouched.
    if (state_q != StIdle && !fall && tmo_hit) begin
      state_d = StIdle;
    end
  end

  assign data  = data_q;
  assign err   = err_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_ps2_rx_controller.sv
// Bench for ps2_rx_controller: drives PS/2 frames with random phase lengths and
// compares every valid strobe against a frame-level reference model.
module tb_ps2_rx_controller;

  localparam int unsigned SYNC = 2;
  localparam int unsigned TMO  = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       err;

  int tests  = 0;
  int failed = 0;

  logic [8:0] cap_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] exp_data = 8'h00;
  logic       exp_err  = 1'b0;

  ps2_rx_controller #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .data    (data),
    .valid   (valid),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Record every cycle with valid high; a stretched pulse shows up as an extra entry.
  always @(negedge clk) begin
    if (valid) cap_q.push_back({err, data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Send the first n bits of a frame, LSB first; leaves ps2_clk high.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      int ph;
      ph       = $urandom_range(4, 7);
      ps2_data = bits[i];
      wait_cycles(ph);
      ps2_clk = 1'b0;
      wait_cycles(ph);
      ps2_clk = 1'b1;
    end
  endtask

  // Full frame plus model update; flip_par corrupts parity, stop is the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic flip_par, input logic stop,
                            input int gap);
    logic par;
    logic e;
    par = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
    par = flip_par ? ~par : par;
    send_bits({stop, par, b, 1'b0}, 11);
    ps2_data = 1'b1;
    e        = flip_par || !stop;
    exp_q.push_back({e, b});
    exp_data = b;
    exp_err  = e;
    wait_cycles(gap);
  endtask

  // Compare all captured strobes with the model, then the held outputs.
  task automatic check_all(input string tag);
    check($sformatf("%s_count", tag), cap_q.size(), exp_q.size());
    while (cap_q.size() > 0 && exp_q.size() > 0) begin
      logic [8:0] c;
      logic [8:0] x;
      c = cap_q.pop_front();
      x = exp_q.pop_front();
      check($sformatf("%s_data", tag), c[7:0], x[7:0]);
      check($sformatf("%s_err", tag), c[8], x[8]);
    end
    cap_q.delete();
    exp_q.delete();
    check($sformatf("%s_hold_data", tag), data, exp_data);
    check($sformatf("%s_hold_err", tag), err, exp_err);
    check($sformatf("%s_valid_low", tag), valid, 1'b0);
  endtask

  initial begin
    // Reset with pins idle.
    rst = 1'b1;
    wait_cycles(2);
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    wait_cycles(5);
    check_all("idle");

    // Single good frame.
    send_frame(8'h24, 1'b0, 1'b1, 6);
    check_all("f24");

    // Back-to-back frames with no idle gap.
    send_frame(8'h81, 1'b0, 1'b1, 0);
    send_frame(8'h07, 1'b0, 1'b1, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 6);
    check_all("b2b");

    // Parity error, then recovery.
    send_frame(8'h07, 1'b1, 1'b1, 6);
    check_all("par_err");
    send_frame(8'h24, 1'b0, 1'b1, 6);
    check_all("par_ok");

    // Stop-bit error.
    send_frame(8'h55, 1'b0, 1'b0, 6);
    check_all("stop_err");

    // Falls with data high while idle are ignored.
    send_bits(11'h7FF, 3);
    wait_cycles(6);
    check_all("idle_falls");

    // Start plus 4 data bits, then stall beyond the timeout.
    send_bits({1'b1, 1'b1, 8'hA5, 1'b0}, 5);
    ps2_data = 1'b1;
    wait_cycles(TMO + 50);
    check_all("timeout");
    send_frame(8'h3C, 1'b0, 1'b1, 6);
    check_all("after_tmo");

    // Randomized frames with occasional parity/stop corruption.
    for (int k = 0; k < 20; k++) begin
      logic [7:0] b;
      logic       fp;
      logic       sb;
      b  = 8'($urandom);
      fp = ($urandom_range(0, 3) == 0);
      sb = ($urandom_range(0, 3) != 0);
      send_frame(b, fp, sb, $urandom_range(0, 8));
    end
    wait_cycles(6);
    check_all("rand");

    // Reset in the middle of a frame discards it and clears outputs.
    send_bits({1'b1, 1'b0, 8'h9A, 1'b0}, 5);
    rst = 1'b1;
    wait_cycles(2);
    check("midrst_data", data, 8'h00);
    check("midrst_err", err, 1'b0);
    check("midrst_valid", valid, 1'b0);
    rst      = 1'b0;
    ps2_data = 1'b1;
    exp_data = 8'h00;
    exp_err  = 1'b0;
    wait_cycles(6);
    check_all("midrst");
    send_frame(8'h5A, 1'b0, 1'b1, 6);
    check_all("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
